// File: rtl/ras_pkg.sv
// ras_pkg: shared widths, default checkpoint layout and modular pointer helpers for the return-address stack.
package ras_pkg;
    localparam int XLEN_DEF = 32;
    localparam int RAS_DEPTH_DEF = 16;
    localparam int FETCH_WIDTH_DEF = 2;
    localparam int PTR_W = $clog2(RAS_DEPTH_DEF);
    localparam int CNT_W = $clog2(RAS_DEPTH_DEF + 1);
    typedef struct packed {
        logic [PTR_W-1:0]    sp;
        logic [XLEN_DEF-1:0] top;
        logic [CNT_W-1:0]    cnt;
    } ras_ckpt_t;
    localparam int CKPT_W = $bits(ras_ckpt_t);
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int ptr_inc(input int p, input int depth);
        return (p + 1) % depth;
    endfunction
    function automatic int ptr_dec(input int p, input int depth);
        return (p + depth - 1) % depth;
    endfunction
endpackage

// File: rtl/ras_op_pick.sv
// ras_op_pick: priority pick of the single stack-op slot in a fetch group.
module ras_op_pick #(
    parameter int FETCH_WIDTH = 2,
    localparam int IW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic [FETCH_WIDTH-1:0] valid,
    input  logic [FETCH_WIDTH-1:0] is_call,
    input  logic [FETCH_WIDTH-1:0] is_ret,
    output logic [IW-1:0]          idx,
    output logic                   op_call,
    output logic                   op_ret,
    output logic [FETCH_WIDTH-1:0] on_path
);
    logic found;
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = FETCH_WIDTH - 1; k >= 0; k--)
            if (valid[k] && (is_call[k] || is_ret[k])) begin
                found = 1'b1;
                idx = IW'(k);
            end
        op_call = found && is_call[idx];
        op_ret = found && !is_call[idx] && is_ret[idx];
        // With no op in the group every slot sees the same, unchanged stack.
        for (int k = 0; k < FETCH_WIDTH; k++)
            on_path[k] = !found || k <= int'(idx);
    end
endmodule

// File: rtl/ras_ckpt.sv
// ras_ckpt: checkpointed return-address stack with per-slot snapshots and redirect repair.
module ras_ckpt import ras_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    localparam int PW = ptr_w(RAS_DEPTH),
    localparam int NW = cnt_w(RAS_DEPTH),
    localparam int CW = PW + XLEN + NW
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [FETCH_WIDTH-1:0]      fetch_valid,
    input  logic [FETCH_WIDTH-1:0]      fetch_is_call,
    input  logic [FETCH_WIDTH-1:0]      fetch_is_ret,
    input  logic [FETCH_WIDTH*XLEN-1:0] fetch_pc,
    output logic [FETCH_WIDTH*XLEN-1:0] ret_addr,
    output logic [FETCH_WIDTH-1:0]      ret_valid,
    output logic [FETCH_WIDTH*CW-1:0]   ckpt,
    output logic [NW-1:0]               occupancy,
    input  logic                        restore,
    input  logic [CW-1:0]               restore_ckpt,
    input  logic                        restore_is_call,
    input  logic                        restore_is_ret,
    input  logic [XLEN-1:0]             restore_pc
);
    localparam int IW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
    typedef struct packed {
        logic [PW-1:0]   sp;
        logic [XLEN-1:0] top;
        logic [NW-1:0]   cnt;
    } ckpt_t;
    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [XLEN-1:0] stack_d [RAS_DEPTH];
    logic [PW-1:0] sp_q, sp_d, base_sp;
    logic [NW-1:0] cnt_q, cnt_d, base_cnt;
    logic [IW-1:0] pick;
    logic pick_call, pick_ret, do_call, do_ret;
    logic [FETCH_WIDTH-1:0] on_path;
    logic [XLEN-1:0] op_pc;
    ckpt_t cur, rc;
    ras_op_pick #(.FETCH_WIDTH(FETCH_WIDTH)) u_pick (
        .valid   (fetch_valid),
        .is_call (fetch_is_call),
        .is_ret  (fetch_is_ret),
        .idx     (pick),
        .op_call (pick_call),
        .op_ret  (pick_ret),
        .on_path (on_path)
    );
    assign rc = restore_ckpt;
    assign cur = '{sp: sp_q, top: stack_q[sp_q], cnt: cnt_q};
    assign occupancy = cnt_q;
    always_comb begin
        ret_addr = '0;
        ret_valid = '0;
        ckpt = '0;
        for (int k = 0; k < FETCH_WIDTH; k++)
            ckpt[k*CW +: CW] = on_path[k] ? cur : '0;
        if (pick_ret && cnt_q != '0) begin
            ret_valid[pick] = 1'b1;
            ret_addr[pick*XLEN +: XLEN] = cur.top;
        end
    end
    // A redirect first rebuilds the snapshot state, then replays its own op on top of it.
    always_comb begin
        stack_d = stack_q;
        base_sp = restore ? rc.sp : sp_q;
        base_cnt = restore ? rc.cnt : cnt_q;
        op_pc = restore ? restore_pc : fetch_pc[pick*XLEN +: XLEN];
        do_call = restore ? restore_is_call : pick_call && !stall;
        do_ret = restore ? restore_is_ret && !restore_is_call : pick_ret && !stall;
        if (restore)
            stack_d[rc.sp] = rc.top;
        sp_d = base_sp;
        cnt_d = base_cnt;
        if (do_call) begin
            sp_d = PW'(ptr_inc(int'(base_sp), RAS_DEPTH));
            stack_d[sp_d] = op_pc + XLEN'(4);
            cnt_d = base_cnt == NW'(RAS_DEPTH) ? base_cnt : base_cnt + NW'(1);
        end else if (do_ret && base_cnt != '0) begin
            sp_d = PW'(ptr_dec(int'(base_sp), RAS_DEPTH));
            cnt_d = base_cnt - NW'(1);
        end
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            sp_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                stack_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            cnt_q <= cnt_d;
            stack_q <= stack_d;
        end
    end
endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed vector table, corner-case sequences and randomized model comparison for ras_ckpt.
module tb_ras_ckpt;
    localparam int XL = 32, FW = 2, D = 16, D4 = 4;
    localparam int PW = $clog2(D), NW = $clog2(D + 1), CW = PW + XL + NW;
    localparam int PW4 = $clog2(D4), NW4 = $clog2(D4 + 1), CW4 = PW4 + XL + NW4;
    logic CLK = 1'b0, reset = 1'b0, stall = 1'b0, restore = 1'b0, rcall = 1'b0, rret = 1'b0;
    logic [FW-1:0] fv = '0, fc = '0, fr = '0;
    logic [FW*XL-1:0] fpc = '0;
    logic [CW-1:0] rck = '0;
    logic [CW4-1:0] rck4 = '0;
    logic [XL-1:0] rpc = '0;
    logic [FW*XL-1:0] ra, ra4;
    logic [FW-1:0] rv, rv4;
    logic [FW*CW-1:0] ck;
    logic [FW*CW4-1:0] ck4;
    logic [NW-1:0] occ;
    logic [NW4-1:0] occ4;
    int n_chk = 0, n_fail = 0;
    ras_ckpt #(.XLEN(XL), .RAS_DEPTH(D), .FETCH_WIDTH(FW)) dut (
        .CLK(CLK), .reset(reset), .stall(stall), .fetch_valid(fv), .fetch_is_call(fc),
        .fetch_is_ret(fr), .fetch_pc(fpc), .ret_addr(ra), .ret_valid(rv), .ckpt(ck),
        .occupancy(occ), .restore(restore), .restore_ckpt(rck), .restore_is_call(rcall),
        .restore_is_ret(rret), .restore_pc(rpc)
    );
    ras_ckpt #(.XLEN(XL), .RAS_DEPTH(D4), .FETCH_WIDTH(FW)) dut4 (
        .CLK(CLK), .reset(reset), .stall(stall), .fetch_valid(fv), .fetch_is_call(fc),
        .fetch_is_ret(fr), .fetch_pc(fpc), .ret_addr(ra4), .ret_valid(rv4), .ckpt(ck4),
        .occupancy(occ4), .restore(restore), .restore_ckpt(rck4), .restore_is_call(rcall),
        .restore_is_ret(rret), .restore_pc(rpc)
    );
    always #5 CLK = ~CLK;
    typedef struct {
        string nm;
        logic s;
        logic [1:0] v, c, r;
        logic [31:0] p0, p1;
        logic [1:0] rv;
        logic [31:0] a0, a1;
        int occ;
        logic [CW-1:0] k0, k1;
    } vec_t;
    vec_t vt[$];
    function automatic logic [CW-1:0] mk(input int sp, input logic [31:0] top, input int cnt);
        return {PW'(sp), top, NW'(cnt)};
    endfunction
    function automatic vec_t vec(input string nm, input logic s, input logic [1:0] v, c, r,
                                 input logic [31:0] p0, p1, input logic [1:0] erv,
                                 input logic [31:0] a0, a1, input int eocc,
                                 input logic [CW-1:0] k0, k1);
        vec_t x;
        x.nm = nm; x.s = s; x.v = v; x.c = c; x.r = r; x.p0 = p0; x.p1 = p1;
        x.rv = erv; x.a0 = a0; x.a1 = a1; x.occ = eocc; x.k0 = k0; x.k1 = k1;
        return x;
    endfunction
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic cyc(input logic s, input logic [1:0] v, c, r, input logic [31:0] p0, p1);
        @(negedge CLK);
        restore = 1'b0; rcall = 1'b0; rret = 1'b0;
        stall = s; fv = v; fc = c; fr = r; fpc = {p1, p0};
        #1;
    endtask
    task automatic rcyc(input logic [CW-1:0] k, input logic rc_, rr_, input logic [31:0] pc,
                        input logic s, input logic [1:0] v, c, r, input logic [31:0] p0);
        @(negedge CLK);
        restore = 1'b1; rck = k; rcall = rc_; rret = rr_; rpc = pc;
        stall = s; fv = v; fc = c; fr = r; fpc = {32'h0, p0};
        #1;
    endtask
    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1; restore = 1'b0; stall = 1'b0; fv = '0; fc = '0; fr = '0;
        @(negedge CLK);
        reset = 1'b0;
    endtask
    // Reference model: the stack as a plain circular array with integer pointer and count.
    logic [31:0] m_st[D];
    int m_sp, m_cnt;
    logic [CW-1:0] hist[$];
    function automatic void m_clear();
        foreach (m_st[i]) m_st[i] = '0;
        m_sp = 0;
        m_cnt = 0;
    endfunction
    function automatic void m_op(input logic is_call, is_ret, input logic [31:0] pc);
        if (is_call) begin
            m_sp = (m_sp + 1) % D;
            m_st[m_sp] = pc + 32'd4;
            m_cnt = m_cnt < D ? m_cnt + 1 : D;
        end else if (is_ret && m_cnt > 0) begin
            m_sp = (m_sp + D - 1) % D;
            m_cnt = m_cnt - 1;
        end
    endfunction
    initial begin
        vt.push_back(vec("call0",      0, 2'b01, 2'b01, 2'b00, 32'h1000, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("ret1",       0, 2'b11, 2'b00, 2'b10, 32'h1100, 32'h1104, 2'b10, 0, 32'h1004, 1,
                         mk(1, 32'h1004, 1), mk(1, 32'h1004, 1)));
        vt.push_back(vec("idle_a",     0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("call0_b",    0, 2'b01, 2'b01, 2'b00, 32'h1000, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("ret0_call1", 0, 2'b11, 2'b10, 2'b01, 32'h1200, 32'h1204, 2'b01, 32'h1004, 0, 1,
                         mk(1, 32'h1004, 1), 0));
        vt.push_back(vec("idle_b",     0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("callret0",   0, 2'b01, 2'b01, 2'b01, 32'h40, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("ret0_c",     0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01, 32'h44, 0, 1, mk(1, 32'h44, 1), 0));
        vt.push_back(vec("underflow",  0, 2'b10, 2'b00, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("invalid",    0, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("stall_call", 1, 2'b01, 2'b01, 2'b00, 32'h500, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("post_stall", 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("call_d",     0, 2'b01, 2'b01, 2'b00, 32'h600, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("stall_ret",  1, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01, 32'h604, 0, 1, mk(1, 32'h604, 1), 0));
        vt.push_back(vec("idle_d",     0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 1,
                         mk(1, 32'h604, 1), mk(1, 32'h604, 1)));
        vt.push_back(vec("ret1_d",     0, 2'b10, 2'b00, 2'b10, 0, 0, 2'b10, 0, 32'h604, 1,
                         mk(1, 32'h604, 1), mk(1, 32'h604, 1)));
        vt.push_back(vec("idle_e",     0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("call_wrap",  0, 2'b01, 2'b01, 2'b00, 32'hFFFF_FFFC, 0, 2'b00, 0, 0, 0, 0, 0));
        vt.push_back(vec("ret_wrap",   0, 2'b01, 2'b00, 2'b01, 0, 0, 2'b01, 0, 0, 1, mk(1, 0, 1), 0));
        vt.push_back(vec("idle_f",     0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        do_reset();
        #1;
        chk("reset_occ", occ, 0);
        chk("reset_rv", rv, 0);
        chk("reset_ra", ra, 0);
        chk("reset_ck", ck, 0);
        foreach (vt[i]) begin
            cyc(vt[i].s, vt[i].v, vt[i].c, vt[i].r, vt[i].p0, vt[i].p1);
            chk({vt[i].nm, "_rv"}, rv, vt[i].rv);
            chk({vt[i].nm, "_a0"}, ra[31:0], vt[i].a0);
            chk({vt[i].nm, "_a1"}, ra[63:32], vt[i].a1);
            chk({vt[i].nm, "_occ"}, occ, vt[i].occ);
            chk({vt[i].nm, "_ck0"}, ck[CW-1:0], vt[i].k0);
            chk({vt[i].nm, "_ck1"}, ck[2*CW-1:CW], vt[i].k1);
        end
        // Checkpoint repair after a wrong path that pops twice and overwrites entry 1.
        do_reset();
        cyc(0, 2'b01, 2'b01, 2'b00, 32'hA00, 0);
        cyc(0, 2'b01, 2'b01, 2'b00, 32'h2000, 0);
        chk("cap_ck0", ck[CW-1:0], mk(1, 32'hA04, 1));
        cyc(0, 2'b01, 2'b00, 2'b01, 0, 0);
        chk("wp_ret1", ra[31:0], 32'h2004);
        cyc(0, 2'b01, 2'b00, 2'b01, 0, 0);
        chk("wp_ret2", ra[31:0], 32'hA04);
        cyc(0, 2'b01, 2'b01, 2'b00, 32'h3000, 0);
        rcyc(mk(1, 32'hA04, 1), 1, 0, 32'h2000, 0, 2'b01, 2'b01, 2'b00, 32'h7000);
        chk("rs_pre_occ", occ, 1);
        cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("rs_occ", occ, 2);
        chk("rs_ck0", ck[CW-1:0], mk(2, 32'h2004, 2));
        cyc(0, 2'b01, 2'b00, 2'b01, 0, 0);
        chk("rs_ret1_rv", rv, 2'b01);
        chk("rs_ret1", ra[31:0], 32'h2004);
        cyc(0, 2'b01, 2'b00, 2'b01, 0, 0);
        chk("rs_ret2", ra[31:0], 32'hA04);
        chk("rs_ret2_occ", occ, 1);
        cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("rs_empty", occ, 0);
        rcyc(mk(0, 0, 0), 0, 1, 32'h50, 0, 2'b01, 2'b01, 2'b00, 32'h8000);
        cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("rs_uf_occ", occ, 0);
        chk("rs_uf_ck0", ck[CW-1:0], mk(0, 0, 0));
        rcyc(mk(3, 32'hBEEF0, 2), 0, 1, 32'h60, 1, 2'b01, 2'b01, 2'b00, 32'h9000);
        cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("rs_stall_occ", occ, 1);
        chk("rs_stall_ck0", ck[CW-1:0], mk(2, 32'h2004, 1));
        // Overflow on the 4-deep stack: oldest entry lost, count saturates.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 2'b01, 2'b01, 2'b00, 32'(i + 1) * 32'h100, 0);
            chk("ovf_occ", occ4, i < 4 ? i : 4);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 2'b01, 2'b00, 2'b01, 0, 0);
            chk("ovf_pop_occ", occ4, 4 - i);
            chk("ovf_pop_rv", rv4, i < 4 ? 2'b01 : 2'b00);
            chk("ovf_pop_ra", ra4[31:0], i < 4 ? 32'(5 - i) * 32'h100 + 32'd4 : 32'd0);
        end
        cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("ovf_end_occ", occ4, 0);
        // Reset pulse in the middle of a push burst.
        do_reset();
        cyc(0, 2'b01, 2'b01, 2'b00, 32'h10, 0);
        cyc(0, 2'b01, 2'b01, 2'b00, 32'h20, 0);
        chk("mid_occ", occ, 1);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0; fc = 2'b00; fr = 2'b01;
        #1;
        chk("mid_rst_occ", occ, 0);
        chk("mid_rst_rv", rv, 0);
        // Randomized traffic against the model.
        do_reset();
        m_clear();
        for (int n = 0; n < 3000; n++) begin
            int f;
            logic [CW-1:0] cur;
            logic [1:0] erv;
            logic [63:0] era;
            logic [2*CW-1:0] eck;
            @(negedge CLK);
            reset = $urandom_range(0, 59) == 0;
            restore = $urandom_range(0, 7) == 0;
            stall = $urandom_range(0, 5) == 0;
            fv = 2'($urandom); fc = 2'($urandom); fr = 2'($urandom);
            fpc = {($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom & ~32'd3, $urandom & ~32'd3};
            rcall = 1'($urandom); rret = 1'($urandom); rpc = $urandom & ~32'd3;
            rck = hist.size() > 0 ? hist[$urandom_range(0, hist.size() - 1)] : '0;
            #1;
            f = -1;
            for (int k = 0; k < FW; k++)
                if (f < 0 && fv[k] && (fc[k] || fr[k])) f = k;
            cur = mk(m_sp, m_st[m_sp], m_cnt);
            eck = '0;
            for (int k = 0; k < FW; k++)
                if (f < 0 || k <= f) eck[k*CW +: CW] = cur;
            erv = '0;
            era = '0;
            if (f >= 0 && !fc[f] && fr[f] && m_cnt > 0) begin
                erv[f] = 1'b1;
                era[f*XL +: XL] = m_st[m_sp];
            end
            chk("rnd_rv", rv, erv);
            chk("rnd_ra", ra, era);
            chk("rnd_ck", ck, eck);
            chk("rnd_occ", occ, m_cnt);
            hist.push_back(cur);
            if (hist.size() > 20) void'(hist.pop_front());
            if (reset) m_clear();
            else if (restore) begin
                m_sp = int'(rck[CW-1 -: PW]);
                m_st[m_sp] = rck[NW +: XL];
                m_cnt = int'(rck[NW-1:0]);
                m_op(rcall, rret, rpc);
            end else if (!stall && f >= 0) m_op(fc[f], fr[f], fpc[f*XL +: XL]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
Parametrised, checkpointed return-address stack for an N-wide predict/decode stage.
- Predicts return targets for up to FETCH_WIDTH slots per cycle.
- Pushes call return addresses speculatively.
- Emits a per-slot checkpoint that travels with each instruction.
- Repairs itself from that checkpoint on an execute-stage redirect.
- Sits beside the BTB/PHT: BTB supplies per-slot call/ret flags; execute drives the restore interface.

Parameters:
XLEN, 32, address width
RAS_DEPTH, 16, stack entries; power of two, >= 2
FETCH_WIDTH, 2, fetch slots per cycle, 1..8

Ports:
CLK  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  fetch group held; no speculative state change
fetch_valid  in  FETCH_WIDTH  slot k holds a valid instruction
fetch_is_call  in  FETCH_WIDTH  BTB flags slot k as call
fetch_is_ret  in  FETCH_WIDTH  BTB flags slot k as return
fetch_pc  in  FETCH_WIDTH*XLEN  pc of slot k (slot k at bits k*XLEN +: XLEN)
ret_addr  out  FETCH_WIDTH*XLEN  predicted return target for slot k
ret_valid  out  FETCH_WIDTH  ret_addr[k] is usable
ckpt  out  FETCH_WIDTH*CKPT_W  ras_ckpt_t snapshot before slot k's op
occupancy  out  CNT_W  live entries, 0..RAS_DEPTH
restore  in  1  execute redirect; repair stack
restore_ckpt  in  CKPT_W  checkpoint of the redirecting instruction
restore_is_call  in  1  redirecting instruction is a call
restore_is_ret  in  1  redirecting instruction is a return
restore_pc  in  XLEN  pc of the redirecting instruction

Behaviour:
State
- stack[RAS_DEPTH] of XLEN.
- sp: PTR_W bits, indexes the top entry.
- cnt: CNT_W bits.
- Reset (synchronous): sp=0, cnt=0, all entries 0.
- Following reset, all outputs are 0 because they derive only from state and inputs.

Slot selection
- Op slot f = lowest k with fetch_valid[k] & (fetch_is_call[k] | fetch_is_ret[k]).
- At most one stack op per cycle; slots above f are off-path.
- If a slot has both call and ret set, call wins.

Outputs (combinational)
- ckpt[k] = {sp, stack[sp], cnt} for every k <= f, and for all k when no op slot exists.
- ckpt[k] = 0 for k > f.
- ret_valid[f] = 1 only when slot f is a return and cnt != 0; then ret_addr[f] = stack[sp].
- All other ret_valid bits = 0; all other ret_addr = 0.

Next state (no restore, no stall)
- Call at f:
  - sp <= sp+1 mod RAS_DEPTH.
  - stack[sp+1] <= fetch_pc[f]+4, mod 2^XLEN.
  - cnt <= min(cnt+1, RAS_DEPTH).
  - On overflow the oldest entry is silently overwritten.
- Ret at f with cnt != 0: sp <= sp-1 mod RAS_DEPTH; cnt <= cnt-1.
- Ret at f with cnt == 0 (underflow): no state change; ret_valid 0.
- stall=1: no state change; outputs still driven.

Restore (priority over fetch and stall; the fetch op in the same cycle is discarded)
- Load sp, stack[ckpt.sp] <= ckpt.top, cnt from restore_ckpt.
- Then apply the redirecting instruction's own op to the restored state in the same cycle:
  - restore_is_call: push restore_pc+4, using the call rules.
  - restore_is_ret: pop, using the ret rules including underflow.
  - Neither flag set: restore only.
- Write conflict: the push writes ckpt.sp+1, never ckpt.sp, so the two writes never collide.
- The result is visible on outputs the cycle after restore.

Reset mid-operation overrides restore, stall and fetch.

Decomposition:
- Package ras_pkg:
  - PTR_W = $clog2(RAS_DEPTH).
  - CNT_W = $clog2(RAS_DEPTH+1).
  - Packed struct ras_ckpt_t {sp, top, cnt}; CKPT_W = $bits(ras_ckpt_t).
  - Helper functions ptr_inc and ptr_dec (modular).
- Sub-module ras_op_pick: combinational priority pick of f, op type and per-slot "before/after f" mask, parametrised by FETCH_WIDTH.
- Storage, pointer and counter logic stay in ras_ckpt.

Test Plan:
- Reset; call at slot0, pc 0x1000; next cycle ret at slot1 -> ret_valid=2'b10, ret_addr[1]=0x1004, occupancy 1 then 0.
- RAS_DEPTH=4: calls at pcs 0x100,0x200,0x300,0x400,0x500, then 5 rets -> 0x504,0x404,0x304,0x204; 5th ret has ret_valid 0 (cnt was 4 after overflow); occupancy saturates at 4.
- Slot0 ret + slot1 call, stack holding 0x1004 -> only the pop happens; ret_addr[0]=0x1004, ret_valid[1]=0, ckpt[1]=0, occupancy -1.
- Push 0xA04; call at pc 0x2000 captures ckpt {sp=1,top=0xA04,cnt=1}; wrong path does ret, ret, then call at 0x3000 (overwrites entry 1); restore with that ckpt and restore_is_call, pc 0x2000 -> next rets give 0x2004 then 0xA04.
- Restore asserted with a fetch call in the same cycle -> fetch push dropped; occupancy equals ckpt.cnt +/- restore op only.
- Stall=1 with a call in slot0 -> sp and occupancy unchanged. Reset pulse in the middle of a push sequence -> occupancy 0; a following ret has ret_valid 0.
